uart_tx: RTL

Serial UART transmitter, the transmit-side partner of the board's UART receive path: 8N1/8E1/8O1 frames at a fixed divisor of the 50 MHz clock (default 115200 baud). Bytes enter through a valid/ready handshake into a small internal FIFO. A bit-timing state machine serialises them LSB first on a single output pin, driven out to a `top[]` header pin by the board top level.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/uart_tx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, baud constants, parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // 50 MHz / 115200 baud, rounded.
  localparam int unsigned CLKS_PER_BIT_115200 = 434;
  // Mid-bit sampling offset used by the receive side.
  localparam int unsigned HALF_BIT_115200     = 217;

  function automatic logic parity_of(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; pointers carry one extra wrap bit so full and empty differ.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];

  assign level = wr_q - rd_q;
  assign full  = (level == FULL_LEVEL);
  assign empty = (wr_q == rd_q);
  assign rdata = mem_q[rd_q[AW-1:0]];

  // Next pointer/storage values for accepted pushes and pops.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push && !full) begin
      mem_d[wr_q[AW-1:0]] = wdata;
      wr_d                = wr_q + 1'b1;
    end
    if (pop && !empty) begin
      rd_d = rd_q + 1'b1;
    end
  end

  // Pointer and storage registers; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop bit serialiser.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST        = (STOP_BITS > 1);
  localparam logic ODD              = (PARITY_ODD != 0);

  tx_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        tx_q, tx_d;

  logic        fifo_pop;
  logic [7:0]  fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic        bit_done;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign tx_ready = !fifo_full;
  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign bit_done = (baud_q == '0);

  // Next-state, baud countdown and serial bit selection.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_done ? BAUD_LAST : baud_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = START;
          shift_d  = fifo_rdata;
          par_d    = parity_of(fifo_rdata, ODD);
          tx_d     = 1'b0;
          baud_d   = BAUD_LAST;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (stop_cnt_q == STOP_LAST) begin
            // Chain straight into the next start bit when a byte is waiting.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              state_d  = START;
              shift_d  = fifo_rdata;
              par_d    = parity_of(fifo_rdata, ODD);
              tx_d     = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; reset forces the line idle-high at once.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

endmodule
